// File: rtl/alu_ctrl_seq.sv
// ---------------------------------------------------------------------------
// alu_ctrl_seq
// Registered ALU-control decoder that sits between the decode stage and the
// ALU/MDU. It turns alu_op/funct3/funct7 into an ALU control code (RV32I plus
// optional RV32M), presents the result through a valid/ready output register,
// and keeps the decode stage stalled while a multi-cycle MUL/DIV occupies the
// execute unit.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          asynchronous active-high reset
//   in_valid     upstream holds a valid alu_op/funct3/funct7
//   in_ready     the block accepts the input this cycle
//   alu_op       00 load/store, 01 branch, 10 R-type, 11 I-type
//   funct3       instruction funct3
//   funct7       instruction funct7
//   out_valid    alu_control/illegal/multi_cycle are valid
//   out_ready    downstream accepts the output
//   alu_control  registered ALU control code
//   illegal      registered flag, the decode was undecodable
//   multi_cycle  registered flag, the op is MUL/DIV-class
//   ex_busy      the execute unit is occupied by a multi-cycle op
// ---------------------------------------------------------------------------
module alu_ctrl_seq #(
   parameter int CTRL_W       = 5,
   parameter int ENABLE_M     = 1,
   parameter int MUL_CYCLES   = 2,
   parameter int DIV_CYCLES   = 33,
   parameter int ILLEGAL_CODE = 19
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        alu_op,
   input  logic [2:0]        funct3,
   input  logic [6:0]        funct7,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] alu_control,
   output logic              illegal,
   output logic              multi_cycle,
   output logic              ex_busy
);

   localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

   localparam logic [CTRL_W-1:0] C_ADD     = CTRL_W'(0);
   localparam logic [CTRL_W-1:0] C_SUB     = CTRL_W'(2);
   localparam logic [CTRL_W-1:0] C_SLT     = CTRL_W'(3);
   localparam logic [CTRL_W-1:0] C_SLTU    = CTRL_W'(4);
   localparam logic [CTRL_W-1:0] C_SLL     = CTRL_W'(7);
   localparam logic [CTRL_W-1:0] C_SRL     = CTRL_W'(8);
   localparam logic [CTRL_W-1:0] C_SRA     = CTRL_W'(9);
   localparam logic [CTRL_W-1:0] C_AND     = CTRL_W'(11);
   localparam logic [CTRL_W-1:0] C_OR      = CTRL_W'(12);
   localparam logic [CTRL_W-1:0] C_XOR     = CTRL_W'(13);
   localparam logic [CTRL_W-1:0] C_MUL     = CTRL_W'(14);
   localparam logic [CTRL_W-1:0] C_MULH    = CTRL_W'(15);
   localparam logic [CTRL_W-1:0] C_DIV     = CTRL_W'(16);
   localparam logic [CTRL_W-1:0] C_DIVU    = CTRL_W'(17);
   localparam logic [CTRL_W-1:0] C_REM     = CTRL_W'(18);
   localparam logic [CTRL_W-1:0] C_REMU    = CTRL_W'(20);
   localparam logic [CTRL_W-1:0] C_MULHSU  = CTRL_W'(21);
   localparam logic [CTRL_W-1:0] C_MULHU   = CTRL_W'(22);
   localparam logic [CTRL_W-1:0] C_ILLEGAL = CTRL_W'(ILLEGAL_CODE);

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MEXT = 7'b0000001;

   typedef enum logic [1:0] {
      IDLE,
      HOLD,
      BUSY
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   counter;
   logic [CTRL_W-1:0]  dec_code;
   logic               dec_illegal;
   logic               dec_multi;
   logic               is_mul_class;
   logic [CNT_W-1:0]   busy_load;

   // Pure combinational decode of the current input fields. Everything starts
   // as illegal and each legal combination overrides it, so any pattern that
   // is not listed falls out as the illegal code without extra cases.
   always_comb begin
      dec_code    = C_ILLEGAL;
      dec_illegal = 1'b1;
      dec_multi   = 1'b0;
      unique case (alu_op)
         2'b00: begin
            dec_code    = C_ADD;
            dec_illegal = 1'b0;
         end
         2'b01: begin
            dec_code    = C_SUB;
            dec_illegal = 1'b0;
         end
         2'b10: begin
            if (funct7 == F7_BASE) begin
               dec_illegal = 1'b0;
               unique case (funct3)
                  3'b000: dec_code = C_ADD;
                  3'b001: dec_code = C_SLL;
                  3'b010: dec_code = C_SLT;
                  3'b011: dec_code = C_SLTU;
                  3'b100: dec_code = C_XOR;
                  3'b101: dec_code = C_SRL;
                  3'b110: dec_code = C_OR;
                  3'b111: dec_code = C_AND;
               endcase
            end else if (funct7 == F7_ALT) begin
               if (funct3 == 3'b000) begin
                  dec_code    = C_SUB;
                  dec_illegal = 1'b0;
               end else if (funct3 == 3'b101) begin
                  dec_code    = C_SRA;
                  dec_illegal = 1'b0;
               end
            end else if ((funct7 == F7_MEXT) && (ENABLE_M != 0)) begin
               dec_illegal = 1'b0;
               dec_multi   = 1'b1;
               unique case (funct3)
                  3'b000: dec_code = C_MUL;
                  3'b001: dec_code = C_MULH;
                  3'b010: dec_code = C_MULHSU;
                  3'b011: dec_code = C_MULHU;
                  3'b100: dec_code = C_DIV;
                  3'b101: dec_code = C_DIVU;
                  3'b110: dec_code = C_REM;
                  3'b111: dec_code = C_REMU;
               endcase
            end
         end
         2'b11: begin
            unique case (funct3)
               3'b000: begin dec_code = C_ADD;  dec_illegal = 1'b0; end
               3'b010: begin dec_code = C_SLT;  dec_illegal = 1'b0; end
               3'b011: begin dec_code = C_SLTU; dec_illegal = 1'b0; end
               3'b100: begin dec_code = C_XOR;  dec_illegal = 1'b0; end
               3'b110: begin dec_code = C_OR;   dec_illegal = 1'b0; end
               3'b111: begin dec_code = C_AND;  dec_illegal = 1'b0; end
               3'b001: begin
                  if (funct7 == F7_BASE) begin
                     dec_code    = C_SLL;
                     dec_illegal = 1'b0;
                  end
               end
               3'b101: begin
                  if (funct7 == F7_BASE) begin
                     dec_code    = C_SRL;
                     dec_illegal = 1'b0;
                  end else if (funct7 == F7_ALT) begin
                     dec_code    = C_SRA;
                     dec_illegal = 1'b0;
                  end
               end
            endcase
         end
      endcase
   end

   // Occupancy of the held op is chosen from its registered code: the
   // multiply family uses MUL_CYCLES and everything else that is multi-cycle
   // is a divide/remainder. The counter is preloaded with LAT-1 so that the
   // BUSY state lasts exactly LAT cycles including the one where it hits 0.
   always_comb begin
      is_mul_class = (alu_control == C_MUL)    || (alu_control == C_MULH) ||
                     (alu_control == C_MULHSU) || (alu_control == C_MULHU);
      busy_load    = is_mul_class ? CNT_W'(MUL_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
   end

   // Input is taken whenever the block is empty, or when the held result is
   // leaving this cycle and it does not send the execute unit into BUSY.
   assign in_ready = (state == IDLE) ||
                     ((state == HOLD) && out_ready && !multi_cycle);

   // Main sequencer: IDLE waits for an op, HOLD presents it until the
   // downstream handshake, BUSY counts down the execute-unit occupancy.
   // Output registers keep their last value whenever nothing new is loaded.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         out_valid   <= 1'b0;
         alu_control <= C_ILLEGAL;
         illegal     <= 1'b0;
         multi_cycle <= 1'b0;
         ex_busy     <= 1'b0;
         counter     <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  alu_control <= dec_code;
                  illegal     <= dec_illegal;
                  multi_cycle <= dec_multi;
                  out_valid   <= 1'b1;
                  state       <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  if (multi_cycle) begin
                     out_valid <= 1'b0;
                     ex_busy   <= 1'b1;
                     counter   <= busy_load;
                     state     <= BUSY;
                  end else if (in_valid) begin
                     alu_control <= dec_code;
                     illegal     <= dec_illegal;
                     multi_cycle <= dec_multi;
                  end else begin
                     out_valid <= 1'b0;
                     state     <= IDLE;
                  end
               end
            end
            BUSY: begin
               if (counter == '0) begin
                  ex_busy <= 1'b0;
                  state   <= IDLE;
               end else begin
                  counter <= counter - 1'b1;
               end
            end
            default: begin
               out_valid <= 1'b0;
               ex_busy   <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_ctrl_seq
// Self-checking bench for alu_ctrl_seq. A default instance (RV32M enabled)
// is exercised by every scenario; a second instance with ENABLE_M=0 shares
// the inputs and is examined for the M-extension-disabled illegal case.
// Expected codes and latencies come from a table-driven reference decoder.
// ---------------------------------------------------------------------------
module tb_alu_ctrl_seq;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic [1:0] alu_op;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       out_ready;

   logic       in_ready;
   logic       out_valid;
   logic [4:0] alu_control;
   logic       illegal;
   logic       multi_cycle;
   logic       ex_busy;

   logic       in_ready_m0;
   logic       out_valid_m0;
   logic [4:0] alu_control_m0;
   logic       illegal_m0;
   logic       multi_cycle_m0;
   logic       ex_busy_m0;

   int tests_run;
   int tests_failed;

   typedef struct packed {
      logic [4:0] code;
      logic       ill;
      logic       mul;
   } exp_t;

   int base_tab[8] = '{0, 7, 3, 4, 13, 8, 12, 11};
   int mext_tab[8] = '{14, 15, 21, 22, 16, 17, 18, 20};

   alu_ctrl_seq dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .alu_op      (alu_op),
      .funct3      (funct3),
      .funct7      (funct7),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .alu_control (alu_control),
      .illegal     (illegal),
      .multi_cycle (multi_cycle),
      .ex_busy     (ex_busy)
   );

   alu_ctrl_seq #(.ENABLE_M(0)) dut_m0 (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready_m0),
      .alu_op      (alu_op),
      .funct3      (funct3),
      .funct7      (funct7),
      .out_valid   (out_valid_m0),
      .out_ready   (out_ready),
      .alu_control (alu_control_m0),
      .illegal     (illegal_m0),
      .multi_cycle (multi_cycle_m0),
      .ex_busy     (ex_busy_m0)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference decoder built from the instruction tables rather than from
   // the hardware case structure.
   function automatic exp_t ref_decode(input logic [1:0] op, input logic [2:0] f3,
                                       input logic [6:0] f7, input bit m_en);
      exp_t e;
      e = '{code: 5'd19, ill: 1'b1, mul: 1'b0};
      if (op == 2'b00) e = '{code: 5'd0, ill: 1'b0, mul: 1'b0};
      else if (op == 2'b01) e = '{code: 5'd2, ill: 1'b0, mul: 1'b0};
      else if (op == 2'b10) begin
         if (f7 == 7'h00) e = '{code: 5'(base_tab[f3]), ill: 1'b0, mul: 1'b0};
         else if (f7 == 7'h20 && f3 == 3'd0) e = '{code: 5'd2, ill: 1'b0, mul: 1'b0};
         else if (f7 == 7'h20 && f3 == 3'd5) e = '{code: 5'd9, ill: 1'b0, mul: 1'b0};
         else if (f7 == 7'h01 && m_en) e = '{code: 5'(mext_tab[f3]), ill: 1'b0, mul: 1'b1};
      end else begin
         if (f3 == 3'd1) begin
            if (f7 == 7'h00) e = '{code: 5'd7, ill: 1'b0, mul: 1'b0};
         end else if (f3 == 3'd5) begin
            if (f7 == 7'h00) e = '{code: 5'd8, ill: 1'b0, mul: 1'b0};
            else if (f7 == 7'h20) e = '{code: 5'd9, ill: 1'b0, mul: 1'b0};
         end else e = '{code: 5'(base_tab[f3]), ill: 1'b0, mul: 1'b0};
      end
      return e;
   endfunction

   // Multiplies (funct3 0..3) occupy 2 cycles, divides/remainders 33.
   function automatic int ref_latency(input logic [2:0] f3);
      return (f3 < 3'd4) ? 2 : 33;
   endfunction

   // Advance one clock and settle just past the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      alu_op = 2'b00; funct3 = 3'd0; funct7 = 7'd0;
      do_reset();
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_valid got %0d want 0", out_valid); end
      tests_run++; if (alu_control !== 5'd19) begin tests_failed++; $display("[TB] FAIL reset_code got %0d want 19", alu_control); end
      tests_run++; if (illegal !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_illegal got %0d want 0", illegal); end
      tests_run++; if (multi_cycle !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_multi got %0d want 0", multi_cycle); end
      tests_run++; if (ex_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_ex_busy got %0d want 0", ex_busy); end
      tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_in_ready got %0d want 1", in_ready); end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      in_valid = 1'b1; alu_op = 2'b10; funct7 = 7'h20; funct3 = 3'd0;
      tick();
      tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_valid1 got %0d want 1", out_valid); end
      tests_run++; if (alu_control !== 5'd2) begin tests_failed++; $display("[TB] FAIL b2b_code_sub got %0d want 2", alu_control); end
      tests_run++; if (illegal !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_illegal1 got %0d want 0", illegal); end
      alu_op = 2'b11; funct3 = 3'd6; funct7 = 7'h55;
      #1;
      tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_in_ready got %0d want 1", in_ready); end
      tick();
      in_valid = 1'b0;
      tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_valid2 got %0d want 1", out_valid); end
      tests_run++; if (alu_control !== 5'd12) begin tests_failed++; $display("[TB] FAIL b2b_code_ori got %0d want 12", alu_control); end
      tests_run++; if (illegal !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_illegal2 got %0d want 0", illegal); end
      tick();
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_drain got %0d want 0", out_valid); end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      in_valid = 1'b1; alu_op = 2'b11; funct3 = 3'd5; funct7 = 7'h20;
      tick();
      alu_op = 2'b00; funct3 = 3'd0; funct7 = 7'h00;
      for (int c = 0; c < 3; c++) begin
         #1;
         tests_run++; if (alu_control !== 5'd9) begin tests_failed++; $display("[TB] FAIL bp_code cycle %0d got %0d want 9", c, alu_control); end
         tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_valid cycle %0d got %0d want 1", c, out_valid); end
         tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_in_ready cycle %0d got %0d want 0", c, in_ready); end
         if (c < 2) tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_release got %0d want 0", out_valid); end
   endtask

   task automatic test_multi(input logic [2:0] f3);
      exp_t e;
      int   lat;
      int   busy_cycles;
      e   = ref_decode(2'b10, f3, 7'h01, 1'b1);
      lat = ref_latency(f3);
      out_ready = 1'b1;
      in_valid = 1'b1; alu_op = 2'b10; funct3 = f3; funct7 = 7'h01;
      tick();
      in_valid = 1'b0;
      #1;
      tests_run++; if (alu_control !== e.code) begin tests_failed++; $display("[TB] FAIL mdu_code f3=%0d got %0d want %0d", f3, alu_control, e.code); end
      tests_run++; if (multi_cycle !== 1'b1) begin tests_failed++; $display("[TB] FAIL mdu_multi f3=%0d got %0d want 1", f3, multi_cycle); end
      tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL mdu_hold_in_ready f3=%0d got %0d want 0", f3, in_ready); end
      tick();
      busy_cycles = 0;
      for (int i = 0; i < 100; i++) begin
         if (ex_busy !== 1'b1) break;
         busy_cycles++;
         tests_run++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL mdu_busy_flags f3=%0d in_ready=%0d out_valid=%0d want 0/0", f3, in_ready, out_valid); end
         tick();
      end
      tests_run++; if (busy_cycles != lat) begin tests_failed++; $display("[TB] FAIL mdu_busy_len f3=%0d got %0d want %0d", f3, busy_cycles, lat); end
      tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL mdu_idle_in_ready f3=%0d got %0d want 1", f3, in_ready); end
      if (busy_cycles != lat) do_reset();
   endtask

   task automatic test_reset_mid_busy();
      out_ready = 1'b1;
      in_valid = 1'b1; alu_op = 2'b10; funct3 = 3'd4; funct7 = 7'h01;
      tick();
      in_valid = 1'b0;
      tick();
      repeat (5) tick();
      tests_run++; if (ex_busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL rstbusy_pre got %0d want 1", ex_busy); end
      rst = 1'b1;
      #1;
      tests_run++; if (ex_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstbusy_ex_busy got %0d want 0", ex_busy); end
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstbusy_out_valid got %0d want 0", out_valid); end
      tick();
      rst = 1'b0;
      tick();
      tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL rstbusy_in_ready got %0d want 1", in_ready); end
      tests_run++; if (ex_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstbusy_after got %0d want 0", ex_busy); end
   endtask

   task automatic test_illegal();
      do_reset();
      in_valid = 1'b1; alu_op = 2'b10; funct7 = 7'h01; funct3 = 3'($urandom_range(0, 7));
      tick();
      in_valid = 1'b0;
      tests_run++; if (alu_control_m0 !== 5'd19) begin tests_failed++; $display("[TB] FAIL nom_code got %0d want 19", alu_control_m0); end
      tests_run++; if (illegal_m0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL nom_illegal got %0d want 1", illegal_m0); end
      tests_run++; if (multi_cycle_m0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL nom_multi got %0d want 0", multi_cycle_m0); end
      tick();
      tests_run++; if (ex_busy_m0 !== 1'b0 || out_valid_m0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL nom_no_busy ex_busy=%0d out_valid=%0d want 0/0", ex_busy_m0, out_valid_m0); end
      tests_run++; if (in_ready_m0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL nom_in_ready got %0d want 1", in_ready_m0); end
      do_reset();
      in_valid = 1'b1; alu_op = 2'b11; funct3 = 3'd1; funct7 = 7'h20;
      tick();
      in_valid = 1'b0;
      tests_run++; if (alu_control !== 5'd19) begin tests_failed++; $display("[TB] FAIL slli_code got %0d want 19", alu_control); end
      tests_run++; if (illegal !== 1'b1) begin tests_failed++; $display("[TB] FAIL slli_illegal got %0d want 1", illegal); end
      tests_run++; if (multi_cycle !== 1'b0) begin tests_failed++; $display("[TB] FAIL slli_multi got %0d want 0", multi_cycle); end
      tick();
      tests_run++; if (ex_busy !== 1'b0 || out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL slli_no_busy ex_busy=%0d out_valid=%0d want 0/0", ex_busy, out_valid); end
   endtask

   task automatic test_random();
      exp_t e;
      int   stalls;
      int   lat;
      int   busy_cycles;
      logic [6:0] f7_pick [4];
      for (int n = 0; n < 30; n++) begin
         f7_pick[0] = 7'h00; f7_pick[1] = 7'h20; f7_pick[2] = 7'h01; f7_pick[3] = 7'($urandom);
         alu_op = 2'($urandom_range(0, 3));
         funct3 = 3'($urandom_range(0, 7));
         funct7 = f7_pick[$urandom_range(0, 3)];
         e      = ref_decode(alu_op, funct3, funct7, 1'b1);
         lat    = ref_latency(funct3);
         stalls = $urandom_range(0, 2);
         in_valid = 1'b1;
         out_ready = 1'b0;
         tick();
         tests_run++; if (out_valid !== 1'b1 || alu_control !== e.code || illegal !== e.ill || multi_cycle !== e.mul) begin
            tests_failed++;
            $display("[TB] FAIL rand_decode n=%0d v/code/ill/mul got %0d/%0d/%0d/%0d want 1/%0d/%0d/%0d", n, out_valid, alu_control, illegal, multi_cycle, e.code, e.ill, e.mul);
         end
         alu_op = 2'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
         for (int s = 0; s < stalls; s++) begin
            tick();
            tests_run++; if (alu_control !== e.code || in_ready !== 1'b0) begin
               tests_failed++;
               $display("[TB] FAIL rand_stall n=%0d code/in_ready got %0d/%0d want %0d/0", n, alu_control, in_ready, e.code);
            end
         end
         in_valid = 1'b0;
         out_ready = 1'b1;
         #1;
         tests_run++; if (in_ready !== !e.mul) begin tests_failed++; $display("[TB] FAIL rand_hs_in_ready n=%0d got %0d want %0d", n, in_ready, !e.mul); end
         tick();
         if (e.mul) begin
            busy_cycles = 0;
            for (int i = 0; i < 100; i++) begin
               if (ex_busy !== 1'b1) break;
               busy_cycles++;
               tick();
            end
            tests_run++; if (busy_cycles != lat) begin tests_failed++; $display("[TB] FAIL rand_busy_len n=%0d got %0d want %0d", n, busy_cycles, lat); end
            if (busy_cycles != lat) do_reset();
         end else begin
            tests_run++; if (out_valid !== 1'b0 || ex_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL rand_drain n=%0d out_valid/ex_busy got %0d/%0d want 0/0", n, out_valid, ex_busy); end
         end
      end
   endtask

   // Scenario sequence followed by the single summary line.
   initial begin
      tests_run = 0;
      tests_failed = 0;
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      alu_op = 2'b00;
      funct3 = 3'd0;
      funct7 = 7'd0;
      test_reset();
      test_back_to_back();
      test_backpressure();
      test_multi(3'd0);
      test_multi(3'd7);
      test_multi(3'd3);
      test_reset_mid_busy();
      test_illegal();
      do_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
